// File: rtl/block_search_scheduler.sv
// block_search_scheduler
// Sequences motion-search candidate offsets for a frame of blocks. For each
// block it walks every vertical offset v = 0..VMAX (outer loop) and, within
// each, every horizontal offset h = HMAX..0 (inner loop), presenting {v,h} on
// a valid/ready handshake. The number of blocks issued but not yet answered
// by the minimum finder (res_valid) is limited to max_inflight.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   start, num_blocks    frame start (IDLE only) and block count
//   abort                stop issuing; drain outstanding results
//   cand_valid/ready     candidate handshake
//   cand_coords          {v[7:0], h[7:0]} offset of the presented candidate
//   cand_blk_index       block index of the presented candidate
//   res_valid            one strobe per finished block
//   busy, done           not-IDLE indicator, one-cycle frame-complete pulse
//   err_unexpected       sticky: a result arrived with nothing in flight
module block_search_scheduler #(
  parameter int blk_h        = 16,
  parameter int blk_w        = 16,
  parameter int search_blk_w = 64,
  parameter int search_blk_h = 32,
  parameter int max_inflight = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] num_blocks,
  input  logic        abort,
  output logic        cand_valid,
  input  logic        cand_ready,
  output logic [15:0] cand_coords,
  output logic [15:0] cand_blk_index,
  input  logic        res_valid,
  output logic        busy,
  output logic        done,
  output logic        err_unexpected
);

  localparam int VMAX_I = search_blk_h - blk_h - 1;
  localparam int HMAX_I = search_blk_w - blk_w - 1;

  generate
    if (VMAX_I < 0 || HMAX_I < 0 || VMAX_I > 255 || HMAX_I > 255) begin : g_bad_window
      $error("block_search_scheduler: search window must exceed block size and fit 8-bit offsets");
    end
    if (max_inflight < 1) begin : g_bad_inflight
      $error("block_search_scheduler: max_inflight must be at least 1");
    end
  endgenerate

  localparam logic [7:0] VMAX = VMAX_I[7:0];
  localparam logic [7:0] HMAX = HMAX_I[7:0];
  localparam int         IFW  = $clog2(max_inflight + 1);
  localparam logic [IFW-1:0] MAX_IF   = IFW'(max_inflight);
  localparam logic [IFW:0]   MAX_IF_X = (IFW+1)'(max_inflight);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_CREDIT, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [7:0]      v_q, v_d, h_q, h_d;
  logic [15:0]     blk_q, blk_d, nb_q, nb_d;
  logic [IFW-1:0]  inflight_q, inflight_d;
  logic            err_q, err_d;

  logic            xfer, last_cand, inc, dec, clr;

  assign cand_valid     = (state_q == ISSUE) && !abort;
  assign cand_coords    = {v_q, h_q};
  assign cand_blk_index = blk_q;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign err_unexpected = err_q;

  assign xfer      = cand_valid && cand_ready;
  assign last_cand = (v_q == VMAX) && (h_q == 8'd0);

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    h_d     = h_q;
    blk_d   = blk_q;
    nb_d    = nb_q;
    err_d   = err_q;
    inc     = 1'b0;
    clr     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          clr   = 1'b1;
          err_d = 1'b0;
          if (num_blocks == 16'd0) begin
            state_d = DONE;
          end else begin
            nb_d    = num_blocks;
            v_d     = 8'd0;
            h_d     = HMAX;
            blk_d   = 16'd0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        // abort masks cand_valid, so xfer is already 0 when abort is high
        if (abort) begin
          state_d = DRAIN;
        end else if (xfer) begin
          if (h_q != 8'd0) begin
            h_d = h_q - 8'd1;
          end else begin
            h_d = HMAX;
            if (last_cand) begin
              v_d   = 8'd0;
              inc   = 1'b1;
              blk_d = blk_q + 16'd1;
              // 17-bit compare so num_blocks = 16'hFFFF finishes without wrap
              if (({1'b0, blk_q} + 17'd1) == {1'b0, nb_q}) begin
                state_d = DRAIN;
              end else if (({1'b0, inflight_q} + (IFW+1)'(1)) == MAX_IF_X) begin
                state_d = WAIT_CREDIT;
              end
            end else begin
              v_d = v_q + 8'd1;
            end
          end
        end
      end
      WAIT_CREDIT: begin
        if (abort) begin
          state_d = DRAIN;
        end else if (inflight_q < MAX_IF) begin
          state_d = ISSUE;
        end
      end
      DRAIN: begin
        if (inflight_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = abort ? DRAIN : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A result that coincides with a final issue cancels it, even from zero.
    dec = res_valid && ((inflight_q != '0) || inc);
    if (res_valid && !dec) begin
      err_d = 1'b1;
    end

    if (clr) begin
      inflight_d = '0;
    end else begin
      inflight_d = inflight_q + IFW'(inc) - IFW'(dec);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      v_q        <= 8'd0;
      h_q        <= 8'd0;
      blk_q      <= 16'd0;
      nb_q       <= 16'd0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      v_q        <= v_d;
      h_q        <= h_d;
      blk_q      <= blk_d;
      nb_q       <= nb_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_block_search_scheduler.sv
module tb_block_search_scheduler;

  localparam int VMAX = 15;
  localparam int HMAX = 47;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_blocks = 16'd0;
  logic        abort = 1'b0;
  logic        cand_ready = 1'b0;
  logic        res_valid = 1'b0;
  logic        cand_valid;
  logic [15:0] cand_coords;
  logic [15:0] cand_blk_index;
  logic        busy;
  logic        done;
  logic        err_unexpected;

  int          n_checks = 0;
  int          n_fail = 0;
  int          xfer_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] first_t, last_t;
  logic        seen_first;

  block_search_scheduler dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .num_blocks     (num_blocks),
    .abort          (abort),
    .cand_valid     (cand_valid),
    .cand_ready     (cand_ready),
    .cand_coords    (cand_coords),
    .cand_blk_index (cand_blk_index),
    .res_valid      (res_valid),
    .busy           (busy),
    .done           (done),
    .err_unexpected (err_unexpected)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int nb);
    for (int b = 0; b < nb; b++)
      for (int v = 0; v <= VMAX; v++)
        for (int h = HMAX; h >= 0; h--)
          exp_q.push_back({16'(b), 8'(v), 8'(h)});
  endtask

  task automatic wait_xfer(input string name, input int target, input int budget);
    int c = 0;
    while (xfer_cnt < target && c < budget) begin
      tick();
      c++;
    end
    chk(name, 32'(xfer_cnt), 32'(target));
  endtask

  task automatic wait_valid(input string name, input int budget);
    int c = 0;
    while (!cand_valid && c < budget) begin
      tick();
      c++;
    end
    chk(name, 32'(cand_valid), 32'd1);
  endtask

  task automatic res_pulse();
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
  endtask

  // Called right after the edge that registered the last result.
  task automatic chk_done_seq(input string name);
    chk({name, "_done_pre"}, 32'(done), 32'd0);
    tick();
    chk({name, "_done"}, 32'(done), 32'd1);
    tick();
    chk({name, "_done_post"}, 32'(done), 32'd0);
    chk({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic start_frame(input logic [15:0] nb);
    num_blocks = nb;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int t, d0, c;

    fork
      forever begin
        @(negedge clk);
        if (reset_n) begin
          if (cand_valid) begin
            if (exp_q.size() == 0) begin
              chk("cand_unexpected", {cand_blk_index, cand_coords}, 32'hFFFF_FFFF);
            end else begin
              chk("cand_tuple", {cand_blk_index, cand_coords}, exp_q[0]);
              if (cand_ready) begin
                if (!seen_first) first_t = {cand_blk_index, cand_coords};
                seen_first = 1'b1;
                last_t = {cand_blk_index, cand_coords};
                void'(exp_q.pop_front());
                xfer_cnt++;
              end
            end
          end
          if (done) done_cnt++;
        end
      end
    join_none

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(cand_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err_unexpected), 32'd0);
    chk("rst_coords", 32'(cand_coords), 32'd0);
    chk("rst_blk", 32'(cand_blk_index), 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // basic frame: one block, always ready
    push_frame(1);
    seen_first = 1'b0;
    d0 = done_cnt;
    t = xfer_cnt;
    cand_ready = 1'b1;
    start_frame(16'd1);
    chk("basic_busy", 32'(busy), 32'd1);
    wait_xfer("basic_xfers", t + 768, 1000);
    chk("basic_first", first_t, 32'h0000_002F);
    chk("basic_last", last_t, 32'h0000_0F00);
    chk("basic_drain_valid", 32'(cand_valid), 32'd0);
    repeat (4) tick();
    chk("basic_no_early_done", 32'(done_cnt - d0), 32'd0);
    res_pulse();
    chk_done_seq("basic");
    chk("basic_done_count", 32'(done_cnt - d0), 32'd1);
    chk("basic_q_empty", 32'(exp_q.size()), 32'd0);
    chk("basic_err", 32'(err_unexpected), 32'd0);

    // credit limit: four blocks, two in flight max
    push_frame(4);
    d0 = done_cnt;
    t = xfer_cnt;
    start_frame(16'd4);
    wait_xfer("credit_xfers", t + 1536, 2000);
    repeat (10) tick();
    chk("credit_hold", 32'(xfer_cnt), 32'(t + 1536));
    chk("credit_wait_valid", 32'(cand_valid), 32'd0);
    chk("credit_wait_busy", 32'(busy), 32'd1);
    res_pulse();
    wait_valid("credit_resume", 10);
    chk("credit_resume_blk", 32'(cand_blk_index), 32'd2);
    chk("credit_resume_coords", 32'(cand_coords), 32'h0000_002F);
    wait_xfer("credit_xfers2", t + 2304, 1000);
    repeat (3) tick();
    chk("credit_wait2_valid", 32'(cand_valid), 32'd0);
    res_pulse();
    wait_xfer("credit_xfers3", t + 3072, 1000);
    res_pulse();
    res_pulse();
    chk_done_seq("credit");
    chk("credit_done_count", 32'(done_cnt - d0), 32'd1);
    chk("credit_q_empty", 32'(exp_q.size()), 32'd0);

    // backpressure: random ready, scoreboard checks every presented cycle
    push_frame(2);
    t = xfer_cnt;
    start_frame(16'd2);
    c = 0;
    while (xfer_cnt < t + 1536 && c < 20000) begin
      cand_ready = 1'($urandom_range(0, 1));
      tick();
      c++;
    end
    chk("bp_xfers", 32'(xfer_cnt), 32'(t + 1536));
    cand_ready = 1'b1;
    res_pulse();
    res_pulse();
    chk_done_seq("bp");
    chk("bp_q_empty", 32'(exp_q.size()), 32'd0);

    // zero blocks
    d0 = done_cnt;
    t = xfer_cnt;
    start_frame(16'd0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_valid", 32'(cand_valid), 32'd0);
    tick();
    chk("zero_done_post", 32'(done), 32'd0);
    chk("zero_idle", 32'(busy), 32'd0);
    chk("zero_done_count", 32'(done_cnt - d0), 32'd1);
    chk("zero_xfers", 32'(xfer_cnt), 32'(t));

    // result while idle
    chk("idle_err_before", 32'(err_unexpected), 32'd0);
    res_pulse();
    chk("idle_err_set", 32'(err_unexpected), 32'd1);
    repeat (3) tick();
    chk("idle_err_sticky", 32'(err_unexpected), 32'd1);
    start_frame(16'd0);
    chk("idle_err_clear", 32'(err_unexpected), 32'd0);
    tick();

    // abort in block 1 with block 0 in flight
    push_frame(2);
    d0 = done_cnt;
    t = xfer_cnt;
    start_frame(16'd2);
    wait_xfer("abort_xfers", t + 868, 1200);
    abort = 1'b1;
    #1;
    chk("abort_valid_now", 32'(cand_valid), 32'd0);
    tick();
    abort = 1'b0;
    exp_q.delete();
    chk("abort_busy", 32'(busy), 32'd1);
    repeat (3) tick();
    chk("abort_drain_valid", 32'(cand_valid), 32'd0);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_no_xfer", 32'(xfer_cnt), 32'(t + 868));
    res_pulse();
    chk_done_seq("abort");
    chk("abort_err", 32'(err_unexpected), 32'd0);

    // reset mid-ISSUE
    push_frame(1);
    d0 = done_cnt;
    t = xfer_cnt;
    start_frame(16'd1);
    wait_xfer("rstmid_xfers", t + 50, 200);
    reset_n = 1'b0;
    #1;
    chk("rstmid_valid", 32'(cand_valid), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_coords", 32'(cand_coords), 32'd0);
    chk("rstmid_blk", 32'(cand_blk_index), 32'd0);
    exp_q.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rstmid_idle", 32'(busy), 32'd0);
    chk("rstmid_err", 32'(err_unexpected), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/block_search_scheduler.md
BLOCK_SEARCH_SCHEDULER -- requirements
Module: block_search_scheduler

Interface
REQ-001 Parameters SHALL be: blk_h, default 16, block height; blk_w, default 16, block width; search_blk_w, default 64, search window width; search_blk_h, default 32, search window height; max_inflight, default 2, maximum blocks issued but not yet resolved.
REQ-002 Ports SHALL be:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  frame start pulse, honoured only in IDLE.
- num_blocks  in  16  block count, sampled on an accepted start.
- abort  in  1  synchronous abort of the current frame.
- cand_valid  out  1  candidate offset valid.
- cand_ready  in  1  datapath accepts the candidate.
- cand_coords  out  16  offset: [15:8] vertical, [7:0] horizontal.
- cand_blk_index  out  16  block index of the candidate.
- res_valid  in  1  per-block result strobe from the minimum finder.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle frame-complete pulse.
- err_unexpected  out  1  sticky flag for a result arriving with nothing in flight.

Function
REQ-003 VMAX SHALL equal search_blk_h-blk_h-1 and HMAX SHALL equal search_blk_w-blk_w-1; both are 8-bit values, and elaboration SHALL fail if either is negative.
REQ-004 Scan order per block SHALL be: v from 0 to VMAX (outer), h from HMAX down to 0 (inner), so the final candidate is {VMAX,8'd0}.
REQ-005 The FSM SHALL have states IDLE, ISSUE, WAIT_CREDIT, DRAIN and DONE.
REQ-006 IDLE: on start with num_blocks!=0, the block SHALL latch num_blocks, clear the counters, set v=0, h=HMAX, blk=0, and go to ISSUE; on start with num_blocks==0 it SHALL go directly to DONE.
REQ-007 ISSUE: cand_valid=1 with cand_coords={v,h} and cand_blk_index=blk.
- A candidate transfers on cand_valid&&cand_ready.
- cand_coords and cand_blk_index SHALL be held stable while cand_valid&&!cand_ready.
REQ-008 A transfer of the final candidate of a block SHALL increment inflight and blk.
- If blk+1==num_blocks, next state is DRAIN.
- Otherwise, if inflight+1==max_inflight, next state is WAIT_CREDIT.
- Otherwise the block stays in ISSUE with v=0, h=HMAX.
REQ-009 WAIT_CREDIT: cand_valid=0; the block SHALL return to ISSUE in the cycle after inflight drops below max_inflight.
REQ-010 DRAIN: cand_valid=0; the block SHALL go to DONE when inflight==0.
REQ-011 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-012 Each cycle with res_valid=1 SHALL decrement inflight.
- When an issuing final transfer and res_valid coincide, inflight SHALL stay unchanged.
- res_valid with inflight==0 SHALL set err_unexpected and leave inflight at 0 (no underflow).
REQ-013 inflight SHALL be wide enough for max_inflight and SHALL never exceed max_inflight.
REQ-014 abort in any non-IDLE state SHALL force cand_valid=0 that cycle and go to DRAIN; no further candidates SHALL be issued, and results still in flight are absorbed.
- abort takes priority over a same-cycle transfer, and the transfer is not counted.
REQ-015 start outside IDLE SHALL be ignored.
REQ-016 err_unexpected SHALL clear only on reset or on an accepted start.
REQ-017 The blk counter SHALL be 16 bits; num_blocks=16'hFFFF SHALL complete without wrap.

Reset
REQ-018 reset_n low SHALL asynchronously force:
- state=IDLE;
- cand_valid=0, busy=0, done=0, err_unexpected=0;
- cand_coords=0, cand_blk_index=0;
- inflight=0, blk=0.
REQ-019 Deassertion of reset_n SHALL be synchronised to clk (external synchroniser); the first start SHALL be honoured on the second clk edge after deassertion.
REQ-020 Reset mid-frame SHALL discard all frame state, with no done pulse.

Verification
REQ-021 Basic frame: defaults, num_blocks=1, cand_ready=1, res_valid 5 cycles after the last transfer -> 768 candidates; first {0,47}; last {15,0}; done one cycle after inflight reaches 0.
REQ-022 Credit limit: max_inflight=2, num_blocks=4, no res_valid -> exactly 1536 transfers, then WAIT_CREDIT; one res_valid -> issue resumes with blk=2, coords {0,47}.
REQ-023 Backpressure: toggle cand_ready randomly -> outputs stable while stalled, no skipped or duplicate {blk,coords} tuples.
REQ-024 Edge cases: start with num_blocks=0 -> done on the next cycle, zero candidates; res_valid while idle -> err_unexpected=1 until the next start.
REQ-025 Abort and reset: abort mid-block 1 with one block in flight -> cand_valid=0 immediately, done after the pending res_valid; reset_n pulse mid-ISSUE -> all outputs 0, no done.
